// File: rtl/shift_seq_gen_if.sv
// Control and pattern bus of the shift-register sequence generator.
// The master drives control and seed; the slave (generator) returns state and strobes.
interface shift_seq_gen_if #(
    parameter int WIDTH = 4
);
    logic             run;
    logic             step;
    logic [1:0]       mode;
    logic             load;
    logic [WIDTH-1:0] seed_in;
    logic [WIDTH-1:0] q;
    logic             tick;
    logic             wrap;
    logic             lockup;

    modport master (
        output run, step, mode, load, seed_in,
        input  q, tick, wrap, lockup
    );

    modport slave (
        input  run, step, mode, load, seed_in,
        output q, tick, wrap, lockup
    );
endinterface

// File: rtl/shift_seq_gen.sv
// Prescaled shift-register sequence generator: LFSR, ring or Johnson stepping
// with seed load, single-step, wrap and LFSR lockup reporting.
module shift_seq_gen #(
    parameter int               WIDTH = 4,
    parameter int               DIV   = 25_000_000,
    parameter logic [WIDTH-1:0] SEED  = {1'b1, {(WIDTH-1){1'b0}}},
    parameter logic [WIDTH-1:0] TAPS  = WIDTH'(4'b1001)
) (
    input  logic            clk,
    input  logic            rst,
    shift_seq_gen_if.slave  bus
);
    localparam int              CW   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0]   LAST = CW'(DIV - 1);

    localparam logic [1:0] MODE_LFSR = 2'b00;
    localparam logic [1:0] MODE_RING = 2'b01;
    localparam logic [1:0] MODE_JOHN = 2'b10;

    logic [CW-1:0]    count;
    logic [WIDTH-1:0] q_r;
    logic [WIDTH-1:0] q_nxt;
    logic             tick_r;
    logic             wrap_r;
    logic             lockup_r;
    logic             lock_nxt;
    logic             shift_en;
    logic             adv;

    assign adv = (bus.run & tick_r) | (~bus.run & bus.step);

    always_comb begin
        q_nxt    = q_r;
        lock_nxt = 1'b0;
        shift_en = 1'b0;
        case (bus.mode)
            MODE_LFSR: begin
                shift_en = 1'b1;
                // All-zero is a dead state for an XOR LFSR; force it back to the seed
                if (q_r == '0) begin
                    q_nxt    = SEED;
                    lock_nxt = 1'b1;
                end else begin
                    q_nxt = {^(q_r & TAPS), q_r[WIDTH-1:1]};
                end
            end
            MODE_RING: begin
                shift_en = 1'b1;
                q_nxt    = {q_r[0], q_r[WIDTH-1:1]};
            end
            MODE_JOHN: begin
                shift_en = 1'b1;
                q_nxt    = {~q_r[0], q_r[WIDTH-1:1]};
            end
            default: begin
                shift_en = 1'b0;
                q_nxt    = q_r;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count    <= '0;
            tick_r   <= 1'b0;
            q_r      <= SEED;
            wrap_r   <= 1'b0;
            lockup_r <= 1'b0;
        end else if (bus.load) begin
            count    <= '0;
            tick_r   <= 1'b0;
            q_r      <= bus.seed_in;
            wrap_r   <= 1'b0;
            lockup_r <= 1'b0;
        end else begin
            count  <= (count == LAST) ? '0 : count + 1'b1;
            tick_r <= (count == LAST);
            if (adv && shift_en) begin
                q_r      <= q_nxt;
                wrap_r   <= (q_nxt == SEED);
                lockup_r <= lock_nxt;
            end else begin
                wrap_r   <= 1'b0;
                lockup_r <= 1'b0;
            end
        end
    end

    assign bus.q      = q_r;
    assign bus.tick   = tick_r;
    assign bus.wrap   = wrap_r;
    assign bus.lockup = lockup_r;
endmodule

// File: tb/tb_shift_seq_gen.sv
// Directed bench for shift_seq_gen: instance a runs with DIV=1, instance b with DIV=5.
module tb_shift_seq_gen;
    logic clk = 1'b0;
    logic rst_a;
    logic rst_b;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    shift_seq_gen_if #(.WIDTH(4)) bus_a ();
    shift_seq_gen_if #(.WIDTH(4)) bus_b ();

    shift_seq_gen #(.WIDTH(4), .DIV(1)) u_a (.clk(clk), .rst(rst_a), .bus(bus_a.slave));
    shift_seq_gen #(.WIDTH(4), .DIV(5)) u_b (.clk(clk), .rst(rst_b), .bus(bus_b.slave));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    logic [3:0] lfsr_seq [16] = '{4'b1000, 4'b1100, 4'b1110, 4'b1111, 4'b0111, 4'b1011,
                                  4'b0101, 4'b1010, 4'b1101, 4'b0110, 4'b0011, 4'b1001,
                                  4'b0100, 4'b0010, 4'b0001, 4'b1000};
    logic [3:0] ring_seq [4]  = '{4'b1000, 4'b0100, 4'b0010, 4'b0001};
    logic [3:0] john_seq [8]  = '{4'b1100, 4'b1110, 4'b1111, 4'b0111,
                                  4'b0011, 4'b0001, 4'b0000, 4'b1000};

    initial begin
        rst_a = 1'b1; rst_b = 1'b1;
        bus_a.run = 1'b1; bus_a.step = 1'b0; bus_a.mode = 2'b00; bus_a.load = 1'b0; bus_a.seed_in = 4'h0;
        bus_b.run = 1'b1; bus_b.step = 1'b0; bus_b.mode = 2'b01; bus_b.load = 1'b0; bus_b.seed_in = 4'h0;
        cyc(); cyc();
        chk("rst_q",      32'(bus_a.q), 32'h8);
        chk("rst_tick",   32'(bus_a.tick), 32'h0);
        chk("rst_wrap",   32'(bus_a.wrap), 32'h0);
        chk("rst_lockup", 32'(bus_a.lockup), 32'h0);

        // LFSR period, DIV=1: first cycle after reset only raises tick
        rst_a = 1'b0;
        cyc();
        chk("lfsr_q0",    32'(bus_a.q), 32'h8);
        chk("lfsr_tick0", 32'(bus_a.tick), 32'h1);
        for (int i = 1; i < 16; i++) begin
            cyc();
            chk($sformatf("lfsr_q%0d", i),    32'(bus_a.q), 32'(lfsr_seq[i]));
            chk($sformatf("lfsr_wrap%0d", i), 32'(bus_a.wrap), 32'(i == 15));
            chk($sformatf("lfsr_lock%0d", i), 32'(bus_a.lockup), 32'h0);
        end

        // Prescaler DIV=5 ring: ticks after edges 5,10,..; advances at 6,11,..
        rst_b = 1'b0;
        for (int n = 1; n <= 25; n++) begin
            cyc();
            chk($sformatf("ring_tick%0d", n), 32'(bus_b.tick), 32'(n % 5 == 0));
            chk($sformatf("ring_q%0d", n),    32'(bus_b.q), 32'(ring_seq[((n - 1) / 5) % 4]));
            chk($sformatf("ring_wrap%0d", n), 32'(bus_b.wrap), 32'(n == 21));
        end

        // Load on a tick edge wins over the shift and restarts the prescaler
        bus_b.load = 1'b1; bus_b.seed_in = 4'b0101;
        cyc();
        bus_b.load = 1'b0;
        chk("ld_q",    32'(bus_b.q), 32'h5);
        chk("ld_tick", 32'(bus_b.tick), 32'h0);
        chk("ld_wrap", 32'(bus_b.wrap), 32'h0);
        for (int n = 27; n <= 31; n++) begin
            cyc();
            chk($sformatf("ld_tick%0d", n), 32'(bus_b.tick), 32'(n == 31));
            chk($sformatf("ld_q%0d", n),    32'(bus_b.q), 32'h5);
        end
        cyc();
        chk("ld_rot", 32'(bus_b.q), 32'hA);

        // Johnson with manual stepping on instance a
        rst_a = 1'b1; bus_a.run = 1'b0; bus_a.mode = 2'b10;
        cyc();
        rst_a = 1'b0;
        for (int n = 0; n < 100; n++) cyc();
        chk("john_idle_q",    32'(bus_a.q), 32'h8);
        chk("john_idle_wrap", 32'(bus_a.wrap), 32'h0);
        for (int i = 0; i < 8; i++) begin
            bus_a.step = 1'b1;
            cyc();
            bus_a.step = 1'b0;
            chk($sformatf("john_q%0d", i),    32'(bus_a.q), 32'(john_seq[i]));
            chk($sformatf("john_wrap%0d", i), 32'(bus_a.wrap), 32'(i == 7));
            cyc();
        end

        // Lockup recovery from an all-zero load
        bus_a.mode = 2'b00; bus_a.load = 1'b1; bus_a.seed_in = 4'b0000;
        cyc();
        bus_a.load = 1'b0;
        chk("lk_load_q",  32'(bus_a.q), 32'h0);
        chk("lk_load_lk", 32'(bus_a.lockup), 32'h0);
        bus_a.step = 1'b1;
        cyc();
        bus_a.step = 1'b0;
        chk("lk_q",    32'(bus_a.q), 32'h8);
        chk("lk_flag", 32'(bus_a.lockup), 32'h1);
        cyc();
        chk("lk_clear", 32'(bus_a.lockup), 32'h0);
        chk("lk_hold",  32'(bus_a.q), 32'h8);
        bus_a.step = 1'b1;
        cyc();
        bus_a.step = 1'b0;
        chk("lk_next", 32'(bus_a.q), 32'hC);

        // Hold mode freezes q across ticks; ring resumes from the frozen value
        bus_a.mode = 2'b11; bus_a.run = 1'b1;
        for (int n = 0; n < 5; n++) begin
            cyc();
            chk($sformatf("hold_q%0d", n),    32'(bus_a.q), 32'hC);
            chk($sformatf("hold_wrap%0d", n), 32'(bus_a.wrap), 32'h0);
        end
        chk("hold_tick", 32'(bus_a.tick), 32'h1);
        bus_a.mode = 2'b01;
        cyc();
        chk("hold_rot", 32'(bus_a.q), 32'h6);

        // Reset dominates a simultaneous load
        rst_a = 1'b1; bus_a.load = 1'b1; bus_a.seed_in = 4'b0101;
        cyc();
        chk("rstld_q",    32'(bus_a.q), 32'h8);
        chk("rstld_tick", 32'(bus_a.tick), 32'h0);
        rst_a = 1'b0; bus_a.load = 1'b0;
        cyc();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
